// File: rtl/param_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// param_univ_shift_reg
//
// Parametrised universal shift register with an op-code select. Multi-bit
// shifts and rotates run as one single-bit step per clock under a
// start/busy/done handshake. Load, clear and hold finish in a single cycle.
// The serial in/out ports allow several instances to be chained.
//
// Parameters
//   WIDTH    register width in bits (>= 2)
//   SHAMT_W  width of amt; step counts 0 .. 2^SHAMT_W-1
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    operation request, sampled only while idle
//   op       000 hold, 001 SHR, 010 SHL, 011 load, 100 ROR, 101 ROL,
//            110 ASR, 111 clear
//   amt      step count for the shift/rotate ops
//   D        parallel load data
//   SI_R     serial input for SHR, enters at the MSB
//   SI_L     serial input for SHL, enters at the LSB
//   Q        register contents
//   SO_R     Q[0], combinational
//   SO_L     Q[WIDTH-1], combinational
//   busy     high while a multi-step operation is in progress
//   done     one-cycle completion pulse
// -----------------------------------------------------------------------------
module param_univ_shift_reg #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] amt,
  input  logic [WIDTH-1:0]   D,
  input  logic               SI_R,
  input  logic               SI_L,
  output logic [WIDTH-1:0]   Q,
  output logic               SO_R,
  output logic               SO_L,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_t             state;
  op_t                op_l;    // operation latched at the start edge
  logic [SHAMT_W-1:0] cnt;     // steps still to perform
  logic [WIDTH-1:0]   step_q;  // Q after one single-bit step of op_l

  // Serial outputs are taps on the register, not separately registered.
  assign SO_R = Q[0];
  assign SO_L = Q[WIDTH-1];

  // One single-bit step. Serial inputs are taken live each step so a chain
  // of instances can stream bits through.
  always_comb begin
    step_q = Q;
    case (op_l)
      OP_SHR:  step_q = {SI_R,       Q[WIDTH-1:1]};
      OP_SHL:  step_q = {Q[WIDTH-2:0], SI_L};
      OP_ROR:  step_q = {Q[0],       Q[WIDTH-1:1]};
      OP_ROL:  step_q = {Q[WIDTH-2:0], Q[WIDTH-1]};
      OP_ASR:  step_q = {Q[WIDTH-1], Q[WIDTH-1:1]};
      default: step_q = Q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      op_l  <= OP_HOLD;
      cnt   <= '0;
      Q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op_t'(op))
              OP_LOAD: begin
                Q    <= D;
                done <= 1'b1;
              end
              OP_CLR: begin
                Q    <= '0;
                done <= 1'b1;
              end
              OP_HOLD: begin
                done <= 1'b1;
              end
              default: begin
                // Shift/rotate: zero steps completes like a hold.
                if (amt == '0) begin
                  done <= 1'b1;
                end else begin
                  op_l  <= op_t'(op);
                  cnt   <= amt;
                  busy  <= 1'b1;
                  state <= SHIFT;
                end
              end
            endcase
          end
        end

        SHIFT: begin
          Q   <= step_q;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_param_univ_shift_reg
//
// Self-checking bench for param_univ_shift_reg (WIDTH=8, SHAMT_W=4).
// A table of vectors preloads Q, runs one operation and compares the final
// value, latency and busy duration against expectations queued at drive time.
// Hand-written sequences cover the start/done handshake and reset mid-shift.
// -----------------------------------------------------------------------------
module tb_param_univ_shift_reg;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [2:0] op;
  logic [3:0] amt;
  logic [7:0] D;
  logic       SI_R;
  logic       SI_L;
  logic [7:0] Q;
  logic       SO_R;
  logic       SO_L;
  logic       busy;
  logic       done;

  int tests;
  int fails;

  param_univ_shift_reg #(
    .WIDTH  (8),
    .SHAMT_W(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .amt    (amt),
    .D      (D),
    .SI_R   (SI_R),
    .SI_L   (SI_L),
    .Q      (Q),
    .SO_R   (SO_R),
    .SO_L   (SO_L),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] init;
    logic [7:0] d;
    logic       sir;
    logic       sil;
    logic [7:0] exp_q;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] q;
    int         lat;
    int         busy_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit is_shift(input logic [2:0] o);
    return (o == 3'b001) || (o == 3'b010) || (o == 3'b100) ||
           (o == 3'b101) || (o == 3'b110);
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input string name, input logic [2:0] o, input logic [3:0] a,
                        input logic [7:0] d, input logic sir, input logic sil,
                        input logic [7:0] eq);
    exp_t e;
    int   lat;
    int   bc;
    e.name     = name;
    e.q        = eq;
    e.lat      = (is_shift(o) && a != 4'd0) ? int'(a) + 1 : 1;
    e.busy_cyc = e.lat - 1;
    sb.push_back(e);
    start = 1'b1; op = o; amt = a; D = d; SI_R = sir; SI_L = sil;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bc  = 0;
    while (!done && lat < 40) begin
      bc += int'(busy);
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check({e.name, " done"},    32'(done),     32'(1));
    check({e.name, " latency"}, 32'(lat),      32'(e.lat));
    check({e.name, " busy"},    32'(bc),       32'(e.busy_cyc));
    check({e.name, " Q"},       32'(Q),        32'(e.q));
    check({e.name, " busy@done"}, 32'(busy),   32'(0));
    check({e.name, " SO_R"},    32'(SO_R),     32'(e.q[0]));
    check({e.name, " SO_L"},    32'(SO_L),     32'(e.q[7]));
  endtask

  initial begin
    int lat;
    int npulse;
    tests = 0;
    fails = 0;

    vecs[0]  = '{"load A5",      3'b011, 4'd0,  8'h00, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{"shr3 si1",     3'b001, 4'd3,  8'hA5, 8'h00, 1'b1, 1'b0, 8'hF4};
    vecs[2]  = '{"ror1",         3'b100, 4'd1,  8'hA5, 8'h00, 1'b0, 1'b0, 8'hD2};
    vecs[3]  = '{"rol8",         3'b101, 4'd8,  8'hA5, 8'h00, 1'b0, 1'b0, 8'hA5};
    vecs[4]  = '{"asr2",         3'b110, 4'd2,  8'h90, 8'h00, 1'b0, 1'b0, 8'hE4};
    vecs[5]  = '{"asr15",        3'b110, 4'd15, 8'h90, 8'h00, 1'b0, 1'b0, 8'hFF};
    vecs[6]  = '{"shl3 si0",     3'b010, 4'd3,  8'hA5, 8'h00, 1'b0, 1'b0, 8'h28};
    vecs[7]  = '{"shr amt0",     3'b001, 4'd0,  8'hA5, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[8]  = '{"clear",        3'b111, 4'd4,  8'hA5, 8'h33, 1'b1, 1'b1, 8'h00};
    vecs[9]  = '{"hold",         3'b000, 4'd6,  8'h3C, 8'hFF, 1'b1, 1'b1, 8'h3C};
    vecs[10] = '{"shl9 si1",     3'b010, 4'd9,  8'h00, 8'h00, 1'b0, 1'b1, 8'hFF};
    vecs[11] = '{"rol1",         3'b101, 4'd1,  8'h81, 8'h00, 1'b0, 1'b0, 8'h03};
    vecs[12] = '{"shr15 si0",    3'b001, 4'd15, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[13] = '{"ror3",         3'b100, 4'd3,  8'h01, 8'h00, 1'b0, 1'b0, 8'h20};

    reset_n = 1'b0; start = 1'b0; op = 3'b000; amt = 4'd0; D = 8'h00;
    SI_R = 1'b0; SI_L = 1'b0;
    #12;
    check("reset Q",    32'(Q),    32'(0));
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors: preload with a load, then the operation under test.
    for (int i = 0; i < 14; i++) begin
      run_op({vecs[i].name, " pre"}, 3'b011, 4'd0, vecs[i].init, 1'b0, 1'b0, vecs[i].init);
      run_op(vecs[i].name, vecs[i].op, vecs[i].amt, vecs[i].d, vecs[i].sir, vecs[i].sil,
             vecs[i].exp_q);
      @(negedge clk);
      check({vecs[i].name, " done width"}, 32'(done), 32'(0));
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    run_op("hs pre", 3'b011, 4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5);
    start = 1'b1; op = 3'b010; amt = 4'd5; SI_L = 1'b0;
    @(negedge clk);
    check("hs busy", 32'(busy), 32'(1));
    start = 1'b1; op = 3'b011; D = 8'h00; amt = 4'd2;
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    lat = 2;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("hs latency", 32'(lat), 32'(6));
    check("hs Q",       32'(Q),   32'(8'hA0));
    start = 1'b1; op = 3'b011; D = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    check("b2b done", 32'(done), 32'(1));
    check("b2b Q",    32'(Q),    32'(8'h5A));
    check("b2b busy", 32'(busy), 32'(0));
    @(negedge clk);
    check("b2b done width", 32'(done), 32'(0));

    // Asynchronous reset in the middle of a rotate.
    run_op("rst pre", 3'b011, 4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5);
    start = 1'b1; op = 3'b101; amt = 4'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst busy before", 32'(busy), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    check("rst Q async",    32'(Q),    32'(0));
    check("rst busy async", 32'(busy), 32'(0));
    check("rst done async", 32'(done), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    npulse = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      npulse += int'(done) + int'(busy);
    end
    check("rst no done", 32'(npulse), 32'(0));
    check("rst Q held",  32'(Q),      32'(0));
    run_op("post rst load", 3'b011, 4'd0, 8'h3C, 1'b0, 1'b0, 8'h3C);
    run_op("post rst ror1", 3'b100, 4'd1, 8'h00, 1'b0, 1'b0, 8'h1E);

    check("scoreboard empty", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
